// File: rtl/comp_search.sv
// Sequential binary-search engine driving the b operand of a magnitude comparator
// and recovering its hidden a operand. Define COMP_SEARCH_SETTLE_EN for registered comparators.
module comp_search #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             e,
  input  logic             l,
  input  logic             g,
  output logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err
);

`ifdef COMP_SEARCH_SETTLE_EN
  typedef enum logic [1:0] {IDLE, PROBE, DONE, SETTLE} state_t;
`else
  typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;
`endif

  localparam logic signed [WIDTH+1:0] ONE = 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] lo, hi, lo_n, hi_n;
  logic [WIDTH-1:0] b_n, result_n;
  logic             busy_n, done_n, found_n, err_n;

  // Range bounds after a g/l step, widened and signed so b+1 past max and b-1 below 0 stay ordered
  logic signed [WIDTH+1:0] up_w, dn_w, lo_w, hi_w;

  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] lo_v,
                                           input logic [WIDTH-1:0] hi_v);
    return lo_v + ((hi_v - lo_v) >> 1);
  endfunction

  always_comb begin
    up_w = $signed({2'b00, b}) + ONE;
    dn_w = $signed({2'b00, b}) - ONE;
    lo_w = $signed({2'b00, lo});
    hi_w = $signed({2'b00, hi});
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo;
    hi_n     = hi;
    b_n      = b;
    result_n = result;
    busy_n   = busy;
    done_n   = 1'b0;
    found_n  = found;
    err_n    = err;

    case (state)
      IDLE: begin
        if (start) begin
          lo_n     = '0;
          hi_n     = '1;
          b_n      = mid('0, '1);
          result_n = '0;
          found_n  = 1'b0;
          err_n    = 1'b0;
          busy_n   = 1'b1;
`ifdef COMP_SEARCH_SETTLE_EN
          state_n  = SETTLE;
`else
          state_n  = PROBE;
`endif
        end
      end

`ifdef COMP_SEARCH_SETTLE_EN
      SETTLE: state_n = PROBE;
`endif

      PROBE: begin
        case ({e, l, g})
          3'b100: begin
            result_n = b;
            found_n  = 1'b1;
            busy_n   = 1'b0;
            done_n   = 1'b1;
            state_n  = DONE;
          end
          3'b001: begin
            if (up_w > hi_w) begin
              err_n   = 1'b1;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              lo_n = up_w[WIDTH-1:0];
              b_n  = mid(up_w[WIDTH-1:0], hi);
`ifdef COMP_SEARCH_SETTLE_EN
              state_n = SETTLE;
`endif
            end
          end
          3'b010: begin
            if (lo_w > dn_w) begin
              err_n   = 1'b1;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              hi_n = dn_w[WIDTH-1:0];
              b_n  = mid(lo, dn_w[WIDTH-1:0]);
`ifdef COMP_SEARCH_SETTLE_EN
              state_n = SETTLE;
`endif
            end
          end
          default: begin
            err_n   = 1'b1;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end
        endcase
      end

      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      b      <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      lo     <= lo_n;
      hi     <= hi_n;
      b      <= b_n;
      result <= result_n;
      busy   <= busy_n;
      done   <= done_n;
      found  <= found_n;
      err    <= err_n;
    end
  end

endmodule

// File: tb/tb_comp_search.sv
// Directed-vector bench for comp_search: combinational comparator model with flag override,
// table of searches plus hand-written reset-abort sequence.
module tb_comp_search;

  localparam int unsigned W = 2;
`ifdef COMP_SEARCH_SETTLE_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         e, l, g;
  logic [W-1:0] b, result;
  logic         busy, done, found, err;

  logic [W-1:0] a_hid = '0;
  logic         force_en = 1'b0;
  logic [2:0]   force_flags = 3'b000;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] bseq [0:7];
  int           nb;
  int           edges;
  logic         got;

  always #5 clk = ~clk;

  assign {e, l, g} = force_en ? force_flags : {a_hid == b, a_hid < b, a_hid > b};

  comp_search #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .e      (e),
    .l      (l),
    .g      (g),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .found  (found),
    .err    (err)
  );

  typedef struct {
    logic [W-1:0] a;
    logic         fen;
    logic [2:0]   ff;
    logic         poke;
    int           probes;
    logic [W-1:0] res;
    logic         fnd;
    logic         er;
    int           nbx;
    logic [W-1:0] b0, b1, b2;
  } vec_t;

  vec_t vecs [0:8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, " b"}, int'(b), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " result"}, int'(result), 0);
    chk({tag, " found"}, int'(found), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  // Pulses start, then follows the search edge by edge until done, recording distinct b values.
  task automatic run_search(input logic [W-1:0] av, input logic fen, input logic [2:0] ff,
                            input logic poke);
    a_hid = av;
    force_en = fen;
    force_flags = ff;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy after start", int'(busy), 1);
    bseq[0] = b;
    nb = 1;
    edges = 0;
    got = 1'b0;
    while (!got && edges < 20) begin
      start = (poke && edges == 1) ? 1'b1 : 1'b0;
      @(posedge clk);
      edges++;
      #1;
      if (done) got = 1'b1;
      else if (b != bseq[nb-1] && nb < 8) begin
        bseq[nb] = b;
        nb++;
      end
    end
    start = 1'b0;
    chk("done seen before timeout", int'(got), 1);
  endtask

  initial begin
    vecs[0] = '{2'd1, 1'b0, 3'b000, 1'b0, 1, 2'd1, 1'b1, 1'b0, 1, 2'd1, 2'd0, 2'd0};
    vecs[1] = '{2'd3, 1'b0, 3'b000, 1'b0, 3, 2'd3, 1'b1, 1'b0, 3, 2'd1, 2'd2, 2'd3};
    vecs[2] = '{2'd0, 1'b0, 3'b000, 1'b0, 2, 2'd0, 1'b1, 1'b0, 2, 2'd1, 2'd0, 2'd0};
    vecs[3] = '{2'd2, 1'b0, 3'b000, 1'b0, 2, 2'd2, 1'b1, 1'b0, 2, 2'd1, 2'd2, 2'd0};
    vecs[4] = '{2'd0, 1'b1, 3'b000, 1'b0, 1, 2'd0, 1'b0, 1'b1, 1, 2'd1, 2'd0, 2'd0};
    vecs[5] = '{2'd0, 1'b1, 3'b101, 1'b0, 1, 2'd0, 1'b0, 1'b1, 1, 2'd1, 2'd0, 2'd0};
    vecs[6] = '{2'd0, 1'b1, 3'b001, 1'b1, 3, 2'd0, 1'b0, 1'b1, 3, 2'd1, 2'd2, 2'd3};
    vecs[7] = '{2'd0, 1'b1, 3'b010, 1'b0, 2, 2'd0, 1'b0, 1'b1, 2, 2'd1, 2'd0, 2'd0};
    vecs[8] = '{2'd0, 1'b1, 3'b011, 1'b0, 1, 2'd0, 1'b0, 1'b1, 1, 2'd1, 2'd0, 2'd0};

    #1;
    chk_zero_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      logic [W-1:0] eb [0:2];
      string tag;
      eb[0] = vecs[i].b0;
      eb[1] = vecs[i].b1;
      eb[2] = vecs[i].b2;
      tag = $sformatf("vec%0d", i);
      run_search(vecs[i].a, vecs[i].fen, vecs[i].ff, vecs[i].poke);
      chk({tag, " done edge"}, edges, vecs[i].probes * STEP);
      chk({tag, " result"}, int'(result), int'(vecs[i].res));
      chk({tag, " found"}, int'(found), int'(vecs[i].fnd));
      chk({tag, " err"}, int'(err), int'(vecs[i].er));
      chk({tag, " busy in done"}, int'(busy), 0);
      chk({tag, " probe count"}, nb, vecs[i].nbx);
      for (int j = 0; j < vecs[i].nbx && j < nb; j++)
        chk($sformatf("%s b[%0d]", tag, j), int'(bseq[j]), int'(eb[j]));
      @(posedge clk);
      #1;
      chk({tag, " done one cycle"}, int'(done), 0);
      chk({tag, " result held"}, int'(result), int'(vecs[i].res));
      chk({tag, " found held"}, int'(found), int'(vecs[i].fnd));
    end

    // Reset asserted mid-search: outputs clear at once and no done pulse follows.
    a_hid = 2'd3;
    force_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (STEP) @(posedge clk);
    #3;
    chk("mid busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async reset");
    got = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    chk("no done after reset", int'(got), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(2'd2, 1'b0, 3'b000, 1'b0);
    chk("restart done edge", edges, 2 * STEP);
    chk("restart result", int'(result), 2);
    chk("restart found", int'(found), 1);
    chk("restart err", int'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
